leds_pwm: RTL

//   Output stage downstream of the 16-bit LED register: takes its registered LED

---
 rtl/leds_pwm.sv | 105 ++++++++++
 1 files changed

// File: rtl/leds_pwm.sv
// PWM dimming output stage for the LED register; settings are double-buffered and applied
// only at PWM period boundaries. Define LEDS_PWM_BLINK_EN to add the per-period blink generator.
module leds_pwm #(
  parameter int unsigned N_LEDS     = 16,
  parameter int unsigned PRESC_DIV  = 4,
  parameter logic [7:0]  DUTY_RESET = 8'hFF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_LEDS-1:0] leds_i,
  input  logic              we_cfg_i,
  input  logic [31:0]       dato_cfg_i,
  output logic [31:0]       cfg_o,
  output logic              periodo_o,
  output logic [N_LEDS-1:0] leds_pad_o
);

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned PWM_W   = 8;
  localparam int unsigned CFG_W   = 13;

  typedef struct packed {
    logic       blink_en;
    logic [3:0] rate;
    logic [7:0] duty;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{blink_en: 1'b0, rate: 4'd0, duty: DUTY_RESET};

  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   pwm_cnt;
  cfg_t               shadow;
  cfg_t               active;
  cfg_t               wr_cfg;
  cfg_t               next_active;
  logic               tick;
  logic               boundary;
  logic               duty_on;
  logic               blink_phase;

  // Period timing and the config value that becomes active at the edge.
  always_comb begin
    tick        = (presc == PRESC_W'(PRESC_DIV - 1));
    boundary    = tick && (pwm_cnt == '1);
    wr_cfg      = cfg_t'(dato_cfg_i[CFG_W-1:0]);
    next_active = active;
    if (boundary) next_active = we_cfg_i ? wr_cfg : shadow;
    duty_on     = (pwm_cnt < active.duty) || (active.duty == 8'hFF);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      shadow     <= CFG_RESET;
      active     <= CFG_RESET;
      periodo_o  <= 1'b0;
      leds_pad_o <= '0;
    end else begin
      presc      <= tick ? '0 : presc + PRESC_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (we_cfg_i) shadow <= wr_cfg;
      active     <= next_active;
      periodo_o  <= boundary;
      leds_pad_o <= leds_i & {N_LEDS{duty_on & blink_phase}};
    end
  end

`ifdef LEDS_PWM_BLINK_EN
  localparam int unsigned BLINK_W = 15;

  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_max;
  logic               blink_restart;

  always_comb begin
    blink_max     = BLINK_W'((32'd1 << active.rate) - 32'd1);
    blink_restart = (next_active.blink_en != active.blink_en) ||
                    (next_active.rate != active.rate) || !active.blink_en;
  end

  // Blink counter advances once per PWM period; a changed blink setting restarts it lit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (boundary) begin
      if (blink_restart) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == blink_max) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
    end
  end
`else
  assign blink_phase = 1'b1;
`endif

  assign cfg_o = {19'b0, active};

endmodule
